// File: rtl/store_align_pkg.sv
// store_align_pkg
// Shared types and lane-alignment helpers for the store alignment queue.
//   size_e  : log2 of the store size in bytes (byte, half, word, dword).
//   state_e : output beat sequencer states.
//   lane_mask / lane_data return double-width results. The low NB lanes
//   form beat0 and the next NB lanes form the split remainder (beat1).
//   The helpers run at a fixed maximum width, and the caller slices them
//   to its own DATA_SIZE (up to MAX_DW).
package store_align_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_e;

  localparam int MAX_DW = 512;
  localparam int MAX_NB = MAX_DW / 8;

  // One bit per written byte, placed at byte offset ofs.
  function automatic logic [2*MAX_NB-1:0] lane_mask(input size_e size,
                                                    input logic [5:0] ofs);
    logic [2*MAX_NB-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_NB; i++) begin
      if (i < (1 << size)) m[i] = 1'b1;
    end
    return m << ofs;
  endfunction

  // Right-justified store data, trimmed to its size and moved to byte offset ofs.
  function automatic logic [2*MAX_DW-1:0] lane_data(input logic [MAX_DW-1:0] data,
                                                    input size_e size,
                                                    input logic [5:0] ofs);
    logic [2*MAX_DW-1:0] d;
    d = '0;
    for (int i = 0; i < MAX_DW; i++) begin
      if (i < (8 << size)) d[i] = data[i];
    end
    return d << {ofs, 3'b000};
  endfunction

endpackage

// File: rtl/store_align_queue_fifo.sv
// store_fifo
// Synchronous FIFO holding queued store entries.
//   clk_i/rst_i : clock, synchronous active-high reset (drops all entries)
//   push_i      : write wdata_i (ignored when full)
//   pop_i       : drop the head entry (ignored when empty)
//   rdata_o     : current head entry (valid when !empty_o)
//   full_o, empty_o, count_o : occupancy, all derived from registered state
module store_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [WIDTH-1:0]               wdata_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage needs no reset; only the pointers define which slots are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/store_align_queue.sv
// store_align_queue
// Queues CPU stores and issues them to the data memory as lane-aligned
// beats with an active-low byte write enable. A store that crosses a word
// boundary is issued as two beats.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   st_valid_i/st_ready_o  : store request handshake
//   st_size_i/addr_i/data_i: log2 bytes, byte address, right-justified data
//   mem_req_o/mem_ack_i    : beat handshake (mem_req_o is registered)
//   mem_addr_o/wdata_o/web_o : word-aligned address, lane data, byte enables
//   err_size_o             : one-cycle pulse when an illegal-size entry is dropped
//   busy_o                 : queue non-empty or a beat outstanding
//
// state | meaning
// IDLE  | no beat on the memory port
// BEAT0 | first (or only) beat of a store presented, waiting for ack
// BEAT1 | split remainder presented, waiting for ack
module store_align_queue
  import store_align_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int DEPTH     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  st_valid_i,
  output logic                  st_ready_o,
  input  logic [1:0]            st_size_i,
  input  logic [ADDR_SIZE-1:0]  st_addr_i,
  input  logic [DATA_SIZE-1:0]  st_data_i,
  output logic                  mem_req_o,
  input  logic                  mem_ack_i,
  output logic [ADDR_SIZE-1:0]  mem_addr_o,
  output logic [DATA_SIZE-1:0]  mem_wdata_o,
  output logic [DATA_SIZE/8-1:0] mem_web_o,
  output logic                  err_size_o,
  output logic                  busy_o
);

  localparam int NB  = DATA_SIZE / 8;
  localparam int OFS = $clog2(NB);
  localparam int EW  = 2 + ADDR_SIZE + DATA_SIZE;
  localparam int CW  = $clog2(DEPTH+1);

  logic [EW-1:0]        head;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic                 pop;

  store_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (st_valid_i & ~fifo_full),
    .pop_i   (pop),
    .wdata_i ({st_size_i, st_addr_i, st_data_i}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  size_e                head_size;
  logic [ADDR_SIZE-1:0] head_addr, head_base, head_next;
  logic [DATA_SIZE-1:0] head_data;
  logic [5:0]           head_ofs;
  logic [2*MAX_NB-1:0]  m2;
  logic [2*MAX_DW-1:0]  d2;
  logic                 head_legal, load_point, load_head, pop_illegal;
  logic                 unused_bits;

  assign head_size = size_e'(head[EW-1 -: 2]);
  assign head_addr = head[DATA_SIZE +: ADDR_SIZE];
  assign head_data = head[DATA_SIZE-1:0];
  assign head_ofs  = 6'(head_addr[OFS-1:0]);
  assign head_base = {head_addr[ADDR_SIZE-1:OFS], {OFS{1'b0}}};
  // Adding at word granularity wraps the beat1 address naturally.
  assign head_next = {head_addr[ADDR_SIZE-1:OFS] + (ADDR_SIZE-OFS)'(1), {OFS{1'b0}}};

  assign m2 = lane_mask(head_size, head_ofs);
  assign d2 = lane_data(MAX_DW'(head_data), head_size, head_ofs);

  // Bits of the max-width helper results beyond our lanes, and the count.
  assign unused_bits = ^{m2, d2, fifo_count};

  assign head_legal = (int'(head_size) <= OFS);

  state_e               state_q;
  logic                 mem_req_q, err_size_q, split_q;
  logic [ADDR_SIZE-1:0] mem_addr_q, rem_addr_q;
  logic [DATA_SIZE-1:0] mem_wdata_q, rem_data_q;
  logic [NB-1:0]        mem_web_q, rem_web_q;

  // A new head may load whenever the port is free or about to be freed.
  always_comb begin
    load_point = 1'b0;
    case (state_q)
      IDLE:    load_point = 1'b1;
      BEAT0:   load_point = mem_ack_i & ~split_q;
      BEAT1:   load_point = mem_ack_i;
      default: load_point = 1'b0;
    endcase
  end

  // Illegal heads are dropped as soon as they surface; they never occupy the port.
  assign pop_illegal = ~fifo_empty & ~head_legal;
  assign load_head   = ~fifo_empty & head_legal & load_point;
  assign pop         = pop_illegal | load_head;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_web_q   <= '1;
      err_size_q  <= 1'b0;
      split_q     <= 1'b0;
      rem_addr_q  <= '0;
      rem_data_q  <= '0;
      rem_web_q   <= '1;
    end else begin
      err_size_q <= pop_illegal;
      if (load_head) begin
        state_q     <= BEAT0;
        mem_req_q   <= 1'b1;
        mem_addr_q  <= head_base;
        mem_wdata_q <= d2[DATA_SIZE-1:0];
        mem_web_q   <= ~m2[NB-1:0];
        split_q     <= |m2[2*NB-1:NB];
        rem_addr_q  <= head_next;
        rem_data_q  <= d2[2*DATA_SIZE-1:DATA_SIZE];
        rem_web_q   <= ~m2[2*NB-1:NB];
      end else if (state_q == BEAT0 && mem_ack_i && split_q) begin
        state_q     <= BEAT1;
        mem_addr_q  <= rem_addr_q;
        mem_wdata_q <= rem_data_q;
        mem_web_q   <= rem_web_q;
        split_q     <= 1'b0;
      end else if (state_q != IDLE && mem_ack_i) begin
        state_q     <= IDLE;
        mem_req_q   <= 1'b0;
        mem_wdata_q <= '0;
        mem_web_q   <= '1;
      end
    end
  end

  assign st_ready_o  = ~fifo_full;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_web_o   = mem_web_q;
  assign err_size_o  = err_size_q;
  assign busy_o      = ~fifo_empty | mem_req_q;

endmodule

// File: tb/tb_store_align_queue.sv
// Testbench for store_align_queue (DATA_SIZE=32, ADDR_SIZE=32, DEPTH=4).
// Expected beats are derived byte by byte from each accepted store and
// queued; a negedge monitor compares every acknowledged beat in order.
module tb_store_align_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_web;
  logic        err_size;
  logic        busy;

  store_align_queue #(.DATA_SIZE(32), .ADDR_SIZE(32), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .st_valid_i  (st_valid),
    .st_ready_o  (st_ready),
    .st_size_i   (st_size),
    .st_addr_i   (st_addr),
    .st_data_i   (st_data),
    .mem_req_o   (mem_req),
    .mem_ack_i   (mem_ack),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_web_o   (mem_web),
    .err_size_o  (err_size),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  w;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    err_exp = 0;
  int    err_seen = 0;
  int    ack_pct = 100;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: place each store byte in its lane, spilling into a second word.
  function automatic void model_push(input logic [1:0] sz, input logic [31:0] a,
                                     input logic [31:0] d);
    int    n, o, p;
    beat_t b0, b1;
    n = 1 << sz;
    if (n > 4) begin
      err_exp++;
      return;
    end
    o = int'(a % 4);
    b0.a = a - 32'(o);
    b1.a = b0.a + 32'd4;
    b0.d = '0; b0.w = 4'hf;
    b1.d = '0; b1.w = 4'hf;
    for (int k = 0; k < n; k++) begin
      p = o + k;
      if (p < 4) begin
        b0.d[8*p +: 8] = d[8*k +: 8];
        b0.w[p] = 1'b0;
      end else begin
        b1.d[8*(p-4) +: 8] = d[8*k +: 8];
        b1.w[p-4] = 1'b0;
      end
    end
    exp_q.push_back(b0);
    if (o + n > 4) exp_q.push_back(b1);
  endfunction

  // Called at posedge+1; presents a request for one cycle.
  task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                      output bit acc);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
    @(negedge clk);
    acc = st_ready;
    if (acc) model_push(sz, a, d);
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic send_wait(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) send(sz, a, d, acc);
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout: got refused expected accepted");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) begin
      total++; bad++;
      $display("FAIL %s_timeout: got %0d beats pending expected 0", nm, exp_q.size());
    end
  endtask

  // Memory acknowledge driver.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_ack = ($urandom_range(0, 99) < ack_pct);
    end
  end

  // Monitor: compare acknowledged beats, check outputs hold while waiting.
  logic [68:0] hold_val;
  bit          hold_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (err_size) err_seen++;
      if (hold_v) check("hold", {mem_req, mem_addr, mem_wdata, mem_web}, hold_val);
      if (mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got addr %0h expected no beat", mem_addr);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_addr", mem_addr, e.a);
          check("beat_wdata", mem_wdata, e.d);
          check("beat_web", mem_web, e.w);
        end
        hold_v = 1'b0;
      end else if (mem_req) begin
        hold_v   = 1'b1;
        hold_val = {mem_req, mem_addr, mem_wdata, mem_web};
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int accepts;
    rst = 1'b1;
    st_valid = 1'b0;
    st_size = '0;
    st_addr = '0;
    st_data = '0;
    idle(3);
    rst = 1'b0;

    check("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_web", mem_web, 4'hf);
    check("rst_err", err_size, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", st_ready, 1'b1);

    // Latency: accepted at edge N, idle after N, request after N+1.
    ack_pct = 100;
    send(2'd2, 32'h100, 32'hAABBCCDD, acc);
    check("lat_acc", acc, 1'b1);
    check("lat_idle", mem_req, 1'b0);
    idle(1);
    check("lat_req", mem_req, 1'b1);
    drain("word");

    send_wait(2'd0, 32'h103, 32'h0000005A);
    send_wait(2'd1, 32'h103, 32'h00001234);
    send_wait(2'd1, 32'hFFFF_FFFF, 32'h0000BEEF);
    drain("byte_half");

    ack_pct = 25;
    send_wait(2'd2, 32'h102, 32'h11223344);
    drain("split_slow");

    // Illegal size: dropped with a single error pulse, no beat.
    ack_pct = 100;
    send_wait(2'd3, 32'h40, 32'hDEADBEEF);
    idle(4);
    check("err_count", err_seen, err_exp);
    check("err_busy", busy, 1'b0);

    // Fill with the port stalled: DEPTH queued plus one held in the beat register.
    ack_pct = 0;
    idle(1);
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      send(2'd2, 32'h200 + 32'(4*i), $urandom, acc);
      if (acc) accepts++;
    end
    check("full_accepts", accepts, DEPTH + 1);
    check("full_ready", st_ready, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_req", mem_req, 1'b0);
    check("mid_rst_web", mem_web, 4'hf);
    check("mid_rst_ready", st_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    ack_pct = 100;
    idle(6);
    check("post_rst_req", mem_req, 1'b0);

    // Random traffic with varying memory stall rate.
    for (int blk = 0; blk < 6; blk++) begin
      ack_pct = $urandom_range(20, 100);
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(0, 99) < 70) begin
          send(2'($urandom_range(0, 3)), $urandom, $urandom, acc);
        end else begin
          idle(1);
        end
      end
    end
    ack_pct = 100;
    drain("random");
    idle(2);
    check("final_err_count", err_seen, err_exp);
    check("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
